// File: rtl/engine_set_ops_configure_request_pkg.sv
// engine_set_ops_configure_request_pkg: shared memory-request, FIFO-signal and FSM types
package engine_set_ops_configure_request_pkg;
  typedef logic [31:0] type_memory_response_offset;
  typedef enum logic [1:0] {CMD_NOP, CMD_READ, CMD_WRITE} type_memory_cmd;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} type_config_request_state;
  typedef struct packed {
    logic [7:0] id_cu;
    logic [7:0] id_bundle;
    logic [7:0] id_lane;
    logic [7:0] id_engine;
    logic [7:0] id_module;
  } type_route;
  typedef struct packed {
    type_memory_response_offset base;
    type_memory_response_offset offset;
  } type_address;
  typedef struct packed {
    type_route      route;
    type_address    address;
    type_memory_cmd cmd;
  } MemoryPacketMeta;
  typedef struct packed {
    MemoryPacketMeta meta;
  } MemoryPacketRequestPayload;
  typedef struct packed {
    logic                      valid;
    MemoryPacketRequestPayload payload;
  } MemoryPacketRequest;
  typedef struct packed {
    logic rd_en;
  } FIFOStateSignalsInput;
  typedef struct packed {
    logic full;
    logic empty;
    logic prog_full;
    logic valid;
  } FIFOStateSignalsOutput;
  typedef struct packed {
    logic full;
    logic empty;
    logic prog_full;
    logic valid;
    logic wr_rst_busy;
    logic rd_rst_busy;
  } FIFOStateSignalsOutInternal;
  function automatic FIFOStateSignalsOutput map_internal_fifo_signals_to_output(input FIFOStateSignalsOutInternal s);
    return '{full: s.full, empty: s.empty, prog_full: s.prog_full, valid: s.valid};
  endfunction
endpackage

// File: rtl/engine_set_ops_configure_request_fifo.sv
// xpm_fifo_sync_wrapper: synchronous standard-read FIFO with prog_full and post-reset busy window
module xpm_fifo_sync_wrapper #(
  parameter int FIFO_WRITE_DEPTH = 16,
  parameter int WRITE_DATA_WIDTH = 32,
  parameter int READ_DATA_WIDTH  = 32,
  parameter int PROG_THRESH      = 8
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic [WRITE_DATA_WIDTH-1:0] din,
  output logic [READ_DATA_WIDTH-1:0]  dout,
  output logic                        full,
  output logic                        empty,
  output logic                        prog_full,
  output logic                        valid,
  output logic                        wr_rst_busy,
  output logic                        rd_rst_busy
);
  localparam int AW = $clog2(FIFO_WRITE_DEPTH);
  logic [WRITE_DATA_WIDTH-1:0] mem [FIFO_WRITE_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [1:0] rst_cnt;
  logic do_wr, do_rd;
  assign wr_rst_busy = srst | (rst_cnt != 2'd0);
  assign rd_rst_busy = wr_rst_busy;
  assign full = cnt == (AW+1)'(FIFO_WRITE_DEPTH);
  assign empty = cnt == '0;
  assign prog_full = cnt >= (AW+1)'(PROG_THRESH);
  assign do_wr = wr_en & ~full & ~wr_rst_busy;
  assign do_rd = rd_en & ~empty & ~rd_rst_busy;
  always_ff @(posedge clk)
    if (srst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      valid <= 1'b0;
      rst_cnt <= 2'd3;
    end else begin
      if (rst_cnt != 2'd0) rst_cnt <= rst_cnt - 2'd1;
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      valid <= do_rd;
    end
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= din;
    if (do_rd) dout <= READ_DATA_WIDTH'(mem[rp]);
  end
endmodule

// File: rtl/engine_set_ops_configure_request.sv
// engine_set_ops_configure_request: issues the configuration read requests for one set-ops engine
module engine_set_ops_configure_request
  import engine_set_ops_configure_request_pkg::*;
#(
  parameter int ID_CU            = 0,
  parameter int ID_BUNDLE        = 0,
  parameter int ID_LANE          = 0,
  parameter int ID_ENGINE        = 0,
  parameter int ID_MODULE        = 0,
  parameter int ID_RELATIVE      = 0,
  parameter int FIFO_WRITE_DEPTH = 16,
  parameter int PROG_THRESH      = 8,
  parameter int ENGINE_SEQ_WIDTH = 16,
  parameter int ENGINE_SEQ_MIN   = ID_RELATIVE * ENGINE_SEQ_WIDTH,
  parameter int ENGINE_SEQ_MAX   = ENGINE_SEQ_MIN + ENGINE_SEQ_WIDTH,
  parameter int CONFIG_WORDS     = 2
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  input  logic                       start_in,
  input  type_memory_response_offset base_address_in,
  output MemoryPacketRequest         request_memory_out,
  input  FIFOStateSignalsInput       fifo_request_memory_out_signals_in,
  output FIFOStateSignalsOutput      fifo_request_memory_out_signals_out,
  output logic                       fifo_setup_signal,
  output logic                       busy_out,
  output logic                       done_out
);
  if (CONFIG_WORDS < 1 || CONFIG_WORDS > ENGINE_SEQ_WIDTH || ENGINE_SEQ_MIN + CONFIG_WORDS > ENGINE_SEQ_MAX) begin : g_bad_cfg
    $error("CONFIG_WORDS must lie in 1..ENGINE_SEQ_WIDTH");
  end
  logic areset_ctrl, areset_fifo;
  type_config_request_state state, next_state;
  logic [ENGINE_SEQ_WIDTH-1:0] count;
  type_memory_response_offset base;
  logic rd_en_reg, push, last, fifo_rd_en;
  MemoryPacketRequestPayload fifo_din, fifo_dout;
  FIFOStateSignalsOutInternal fifo_sig;
  always_ff @(posedge ap_clk) begin
    areset_ctrl <= areset;
    areset_fifo <= areset;
  end
  assign last = count == ENGINE_SEQ_WIDTH'(CONFIG_WORDS - 1);
  assign push = (state == ISSUE) & ~fifo_sig.prog_full & ~fifo_sig.full & ~fifo_setup_signal;
  assign fifo_rd_en = rd_en_reg & ~fifo_sig.empty;
  assign busy_out = state != IDLE;
  assign done_out = state == DONE;
  // Drain completes only once the FIFO, its read stage and the output register are all empty.
  always_comb
    next_state = state == IDLE  ? (start_in & ~fifo_setup_signal ? ISSUE : IDLE) :
                 state == ISSUE ? (push & last ? DRAIN : ISSUE) :
                 state == DRAIN ? (fifo_sig.empty & ~fifo_sig.valid & ~request_memory_out.valid ? DONE : DRAIN) :
                 IDLE;
  always_ff @(posedge ap_clk)
    if (areset_ctrl) begin
      state <= IDLE;
      count <= '0;
      base <= '0;
      rd_en_reg <= 1'b0;
      request_memory_out <= '0;
      fifo_request_memory_out_signals_out <= '0;
    end else begin
      state <= next_state;
      count <= state == IDLE ? '0 : count + ENGINE_SEQ_WIDTH'(push & ~last);
      if (state == IDLE) base <= base_address_in;
      rd_en_reg <= fifo_request_memory_out_signals_in.rd_en;
      request_memory_out.valid <= fifo_sig.valid;
      request_memory_out.payload <= fifo_dout;
      fifo_request_memory_out_signals_out <= map_internal_fifo_signals_to_output(fifo_sig);
    end
  always_ff @(posedge ap_clk)
    if (areset_fifo) fifo_setup_signal <= 1'b1;
    else fifo_setup_signal <= fifo_sig.wr_rst_busy | fifo_sig.rd_rst_busy;
  always_comb begin
    fifo_din = '0;
    fifo_din.meta.route.id_cu = 8'(ID_CU);
    fifo_din.meta.route.id_bundle = 8'(ID_BUNDLE);
    fifo_din.meta.route.id_lane = 8'(ID_LANE);
    fifo_din.meta.route.id_engine = 8'(ID_ENGINE);
    fifo_din.meta.route.id_module = 8'(ID_MODULE);
    fifo_din.meta.address.base = base;
    fifo_din.meta.address.offset = type_memory_response_offset'(ENGINE_SEQ_WIDTH'(ENGINE_SEQ_MIN) + count);
    fifo_din.meta.cmd = CMD_READ;
  end
  xpm_fifo_sync_wrapper #(
    .FIFO_WRITE_DEPTH(FIFO_WRITE_DEPTH),
    .WRITE_DATA_WIDTH($bits(MemoryPacketRequestPayload)),
    .READ_DATA_WIDTH ($bits(MemoryPacketRequestPayload)),
    .PROG_THRESH     (PROG_THRESH)
  ) u_fifo (
    .clk        (ap_clk),
    .srst       (areset_fifo),
    .wr_en      (push),
    .rd_en      (fifo_rd_en),
    .din        (fifo_din),
    .dout       (fifo_dout),
    .full       (fifo_sig.full),
    .empty      (fifo_sig.empty),
    .prog_full  (fifo_sig.prog_full),
    .valid      (fifo_sig.valid),
    .wr_rst_busy(fifo_sig.wr_rst_busy),
    .rd_rst_busy(fifo_sig.rd_rst_busy)
  );
endmodule

// File: tb/tb_engine_set_ops_configure_request.sv
// tb_engine_set_ops_configure_request: directed checks on three configurations of the request engine
module tb_engine_set_ops_configure_request;
  import engine_set_ops_configure_request_pkg::*;
  logic clk = 1'b0;
  logic areset = 1'b1;
  logic start[3] = '{1'b0, 1'b0, 1'b0};
  type_memory_response_offset base[3] = '{32'h0, 32'h0, 32'h0};
  FIFOStateSignalsInput rd[3] = '{1'b1, 1'b0, 1'b0};
  MemoryPacketRequest req[3];
  FIFOStateSignalsOutput so[3];
  logic setup[3], busy[3], done[3];
  MemoryPacketRequestPayload p0[$], p1[$], p2[$];
  int dn[3] = '{0, 0, 0};
  int di[3] = '{0, 0, 0};
  int tests = 0;
  int fails = 0;
  int d0;
  always #5 clk = ~clk;
  engine_set_ops_configure_request #(.ID_CU(3), .ID_ENGINE(5), .ID_RELATIVE(1), .CONFIG_WORDS(2)) u0 (
    .ap_clk(clk), .areset(areset), .start_in(start[0]), .base_address_in(base[0]),
    .request_memory_out(req[0]), .fifo_request_memory_out_signals_in(rd[0]),
    .fifo_request_memory_out_signals_out(so[0]), .fifo_setup_signal(setup[0]),
    .busy_out(busy[0]), .done_out(done[0]));
  engine_set_ops_configure_request #(.ID_RELATIVE(1), .CONFIG_WORDS(12)) u1 (
    .ap_clk(clk), .areset(areset), .start_in(start[1]), .base_address_in(base[1]),
    .request_memory_out(req[1]), .fifo_request_memory_out_signals_in(rd[1]),
    .fifo_request_memory_out_signals_out(so[1]), .fifo_setup_signal(setup[1]),
    .busy_out(busy[1]), .done_out(done[1]));
  engine_set_ops_configure_request #(.ID_RELATIVE(1), .CONFIG_WORDS(4)) u2 (
    .ap_clk(clk), .areset(areset), .start_in(start[2]), .base_address_in(base[2]),
    .request_memory_out(req[2]), .fifo_request_memory_out_signals_in(rd[2]),
    .fifo_request_memory_out_signals_out(so[2]), .fifo_setup_signal(setup[2]),
    .busy_out(busy[2]), .done_out(done[2]));
  always @(negedge clk) begin
    if (req[0].valid) p0.push_back(req[0].payload);
    if (req[1].valid) p1.push_back(req[1].payload);
    if (req[2].valid) p2.push_back(req[2].payload);
    if (done[0]) begin dn[0]++; di[0] = p0.size(); end
    if (done[1]) begin dn[1]++; di[1] = p1.size(); end
    if (done[2]) begin dn[2]++; di[2] = p2.size(); end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse(input int k, input type_memory_response_offset b);
    base[k] = b;
    start[k] = 1'b1;
    @(posedge clk);
    #1 start[k] = 1'b0;
  endtask
  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 64'(busy[k]), 64'(0));
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    repeat (4) @(negedge clk);
    chk("rst_valid", 64'(req[0].valid), 64'(0));
    chk("rst_done", 64'(done[0]), 64'(0));
    chk("rst_busy", 64'(busy[0]), 64'(0));
    chk("rst_setup", 64'(setup[0]), 64'(1));
    // start pulsed while the FIFO is still coming out of reset
    @(posedge clk);
    #1 areset = 1'b0;
    start[0] = 1'b1;
    base[0] = 32'h500;
    @(negedge clk);
    chk("t5_setup_high", 64'(setup[0]), 64'(1));
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_busy_low", 64'(busy[0]), 64'(0));
    end
    repeat (10) @(negedge clk);
    chk("t5_setup_clear", 64'(setup[0]), 64'(0));
    chk("t5_no_output", 64'(p0.size()), 64'(0));
    // test 1: two reads at offsets 16, 17
    pulse(0, 32'h100);
    wait_idle(0);
    chk("t1_count", 64'(p0.size()), 64'(2));
    chk("t1_off0", 64'(p0[0].meta.address.offset), 64'(16));
    chk("t1_off1", 64'(p0[1].meta.address.offset), 64'(17));
    chk("t1_base0", 64'(p0[0].meta.address.base), 64'(32'h100));
    chk("t1_base1", 64'(p0[1].meta.address.base), 64'(32'h100));
    chk("t1_cmd", 64'(p0[0].meta.cmd), 64'(CMD_READ));
    chk("t1_id_cu", 64'(p0[0].meta.route.id_cu), 64'(3));
    chk("t1_id_engine", 64'(p0[0].meta.route.id_engine), 64'(5));
    chk("t1_done_count", 64'(dn[0]), 64'(1));
    chk("t1_done_after_last", 64'(di[0]), 64'(2));
    // test 3: second start during ISSUE is ignored
    p0.delete();
    d0 = dn[0];
    pulse(0, 32'h300);
    chk("t3_busy", 64'(busy[0]), 64'(1));
    pulse(0, 32'h200);
    wait_idle(0);
    repeat (4) @(negedge clk);
    chk("t3_idle_after", 64'(busy[0]), 64'(0));
    chk("t3_count", 64'(p0.size()), 64'(2));
    chk("t3_base0", 64'(p0[0].meta.address.base), 64'(32'h300));
    chk("t3_base1", 64'(p0[1].meta.address.base), 64'(32'h300));
    chk("t3_done_once", 64'(dn[0] - d0), 64'(1));
    // test 4: reset in the middle of a sequence
    p0.delete();
    d0 = dn[0];
    rd[0].rd_en = 1'b0;
    pulse(0, 32'h100);
    @(posedge clk);
    #1 areset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_busy", 64'(busy[0]), 64'(0));
    chk("t4_valid", 64'(req[0].valid), 64'(0));
    chk("t4_done", 64'(done[0]), 64'(0));
    chk("t4_setup", 64'(setup[0]), 64'(1));
    @(posedge clk);
    #1 areset = 1'b0;
    repeat (12) @(negedge clk);
    chk("t4_setup_clear", 64'(setup[0]), 64'(0));
    rd[0].rd_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_flushed", 64'(p0.size()), 64'(0));
    chk("t4_no_done", 64'(dn[0] - d0), 64'(0));
    pulse(0, 32'h100);
    wait_idle(0);
    chk("t4_count", 64'(p0.size()), 64'(2));
    chk("t4_off0", 64'(p0[0].meta.address.offset), 64'(16));
    chk("t4_off1", 64'(p0[1].meta.address.offset), 64'(17));
    chk("t4_done_once", 64'(dn[0] - d0), 64'(1));
    // test 2: prog_full stalls pushes until the consumer drains
    pulse(1, 32'h40);
    repeat (25) @(negedge clk);
    chk("t2_prog_full", 64'(so[1].prog_full), 64'(1));
    chk("t2_not_full", 64'(so[1].full), 64'(0));
    chk("t2_busy", 64'(busy[1]), 64'(1));
    chk("t2_no_output", 64'(p1.size()), 64'(0));
    chk("t2_no_done", 64'(dn[1]), 64'(0));
    rd[1].rd_en = 1'b1;
    wait_idle(1);
    chk("t2_count", 64'(p1.size()), 64'(12));
    for (int i = 0; i < 12 && i < p1.size(); i++)
      chk($sformatf("t2_off%0d", i), 64'(p1[i].meta.address.offset), 64'(16 + i));
    chk("t2_base", 64'(p1[0].meta.address.base), 64'(32'h40));
    chk("t2_done_once", 64'(dn[1]), 64'(1));
    chk("t2_done_after_last", 64'(di[1]), 64'(12));
    // test 6: rd_en toggling every cycle
    rd[2].rd_en = 1'b1;
    pulse(2, 32'h80);
    for (int i = 0; i < 300 && busy[2]; i++) begin
      @(posedge clk);
      #1 rd[2].rd_en = ~rd[2].rd_en;
    end
    chk("t6_idle", 64'(busy[2]), 64'(0));
    chk("t6_count", 64'(p2.size()), 64'(4));
    for (int i = 0; i < 4 && i < p2.size(); i++)
      chk($sformatf("t6_off%0d", i), 64'(p2[i].meta.address.offset), 64'(16 + i));
    chk("t6_done_once", 64'(dn[2]), 64'(1));
    chk("t6_done_after_last", 64'(di[2]), 64'(4));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
